uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clocks per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, idle cycles after which a packet lock is dropped; legal range 1..65535.
REQ-003 SHALL have port clk_50MHz, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester byte available.
REQ-006 SHALL have ports req0_data / req1_data, input, 8 each: byte to send, LSB first.
REQ-007 SHALL have ports req0_last / req1_last, input, 1 each: byte ends the requester's packet.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each: byte accepted this cycle when valid is also high.
REQ-009 SHALL have port grant, output, 2: one-hot current packet owner, 2'b00 when unowned.
REQ-010 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-011 SHALL have port uart_txd, output, 1: serial 8N1 line, idle high.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START on byte accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bit periods; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 SHALL drive uart_txd 1 in IDLE and STOP, 0 in START, and data bit n (n = 0..7) in DATA bit period n.
REQ-014 SHALL accept a byte only in IDLE; ready high for exactly that one cycle, for the selected requester only, and only while its valid is high.
REQ-015 SHALL register the accepted byte in the accept cycle; uart_txd falls on the following cycle; frame lasts exactly 10*CLKS_PER_BIT cycles; back-to-back frames repeat every 10*CLKS_PER_BIT+1 cycles.
REQ-016 SHALL, when unowned in IDLE, select by round robin: a single valid requester wins; with both valid, the requester other than the previous owner wins; after reset requester 0 has priority.
REQ-017 SHALL set grant to the winner on accept and hold it (lock) until a byte with last=1 from the owner is accepted, releasing at the end of that frame's STOP.
REQ-018 SHALL, while locked, never accept from the non-owner, even if the owner's valid is low.
REQ-019 SHALL count consecutive IDLE cycles with owner valid low while locked; on reaching LOCK_TIMEOUT, clear grant in that cycle and arbitrate from the next cycle.
REQ-020 SHALL treat a valid byte with last=1 as a single-byte packet, and ignore the last input of a non-owner.
REQ-021 SHALL not require data/last to be stable before ready; sampled only in the accept cycle.
REQ-022 SHALL size bit-period and timeout counters to $clog2(parameter+1) bits; no counter wraps during normal operation.

Reset
REQ-023 SHALL, on arst_n low at a clock edge, force state IDLE, uart_txd 1, busy 0, grant 2'b00, both ready 0, counters 0, round-robin priority to requester 0.
REQ-024 SHALL abort any frame in progress on reset, leaving uart_txd high from the cycle after the reset edge; the aborted byte is not resent.

Structure
REQ-025 SHALL place the FSM state enum and the default CLKS_PER_BIT/LOCK_TIMEOUT constants in a shared package uart_tx_arb_pkg.
REQ-026 SHALL instantiate one sub-module uart_tx_ser (8N1 shifter plus bit-period counter, load/busy handshake); arbitration and lock logic stay in uart_tx_arb.

Verification (CLKS_PER_BIT=4, LOCK_TIMEOUT=8)
REQ-027 SHALL check single byte: req0 sends 0xA5 with last=1 -> ready0 one cycle, uart_txd 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, busy for 40 cycles, grant returns to 00.
REQ-028 SHALL check contention: both valid from reset with single-byte packets 0x11/0x22 -> order 0x11, 0x22, 0x11; frame starts 41 cycles apart.
REQ-029 SHALL check lock: req0 sends a 3-byte packet while req1 is held valid -> all three req0 bytes sent before any req1 byte, grant stays 01 throughout.
REQ-030 SHALL check timeout: req0 sends 1 byte with last=0 then drops valid, req1 valid -> grant clears 8 IDLE cycles after the frame, and req1 is accepted on the next cycle.
REQ-031 SHALL check reset mid-frame: arst_n low during DATA bit 3 -> next cycle uart_txd 1, busy 0, grant 00; after release, req1 alone is served first.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: definitions shared by the two-requester UART transmitter.
//   - default bit period (115200 baud at 50 MHz) and default packet-lock timeout
//   - serializer FSM state encoding
//   - helper that turns a requester index into a one-hot grant
package uart_tx_arb_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DEFAULT_LOCK_TIMEOUT = 1024;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t ST_IDLE  = 2'd0;
   localparam tx_state_t ST_START = 2'd1;
   localparam tx_state_t ST_DATA  = 2'd2;
   localparam tx_state_t ST_STOP  = 2'd3;

   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: 8N1 serializer with bit-period counter.
// Ports:
//   clk_50MHz  in   clock, rising edge
//   arst_n     in   synchronous active-low reset
//   load       in   accept data (only acted on while idle)
//   data[7:0]  in   byte to send, LSB first
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle pulse in the last cycle of the stop bit
//   txd        out  serial line, idle high
module uart_tx_ser
   import uart_tx_arb_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk_50MHz,
   input  logic       arst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       txd
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             bit_end;

   assign bit_end = (bit_cnt == BIT_END);
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_STOP) && bit_end;

   // txd is registered and changes together with the state, so the line
   // never glitches between bit periods.
   always_ff @(posedge clk_50MHz) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one.
      if (!arst_n) begin
         state   <= ST_IDLE;
         txd     <= 1'b1;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  shreg   <= data;
                  txd     <= 1'b0;
                  bit_cnt <= '0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  txd     <= shreg[0];
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     // shift right so the next data bit is always shreg[1]
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two requesters share one 8N1 UART transmitter.
// Round-robin arbitration per packet; the winner keeps the line (lock)
// until its last byte has been sent, or until it stays silent for
// LOCK_TIMEOUT idle cycles.
// Ports:
//   clk_50MHz               in   clock, rising edge
//   arst_n                  in   synchronous active-low reset
//   reqN_valid/data/last    in   requester N byte, LSB first, end-of-packet
//   reqN_ready              out  byte taken this cycle (when valid high)
//   grant[1:0]              out  one-hot packet owner, 00 when unowned
//   busy                    out  serializer not idle
//   uart_txd                out  serial line, idle high
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
   input  logic       clk_50MHz,
   input  logic       arst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req0_ready,
   output logic       req1_ready,
   output logic [1:0] grant,
   output logic       busy,
   output logic       uart_txd
);

   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_END = TO_W'(LOCK_TIMEOUT - 1);

   logic            sel;          // requester considered this cycle
   logic            sel_valid;
   logic            sel_last;
   logic [7:0]      sel_data;
   logic            accept;
   logic            locked;
   logic            owner_quiet;  // locked, idle and owner has nothing
   logic            timeout_hit;
   logic            prio_req1;    // requester 1 wins the next tie
   logic            release_pend; // owner's last byte is on the line
   logic [TO_W-1:0] idle_cnt;
   logic            ser_done;

   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = 1'b0;
      if (grant != 2'b00)
         sel = grant[1];            // locked: only the owner is considered
      else if (req0_valid && req1_valid)
         sel = prio_req1;
      else
         sel = req1_valid;
   end

   assign locked      = (grant != 2'b00);
   assign sel_valid   = sel ? req1_valid : req0_valid;
   assign sel_last    = sel ? req1_last  : req0_last;
   assign sel_data    = sel ? req1_data  : req0_data;
   assign accept      = arst_n && !busy && sel_valid;
   assign req0_ready  = accept && !sel;
   assign req1_ready  = accept &&  sel;
   assign owner_quiet = locked && !release_pend && !busy && !sel_valid;
   assign timeout_hit = owner_quiet && (idle_cnt == TO_END);

   always_ff @(posedge clk_50MHz) begin
      if (!arst_n) begin
         grant        <= 2'b00;
         prio_req1    <= 1'b0;
         release_pend <= 1'b0;
         idle_cnt     <= '0;
      end else begin
         if (accept) begin
            grant        <= req_onehot(sel);
            prio_req1    <= ~sel;
            release_pend <= sel_last;
         end else if (ser_done && release_pend) begin
            grant        <= 2'b00;
            release_pend <= 1'b0;
         end else if (timeout_hit) begin
            grant <= 2'b00;
         end

         if (owner_quiet)
            idle_cnt <= timeout_hit ? '0 : idle_cnt + TO_W'(1);
         else
            idle_cnt <= '0;
      end
   end

   uart_tx_ser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk_50MHz(clk_50MHz),
      .arst_n   (arst_n),
      .load     (accept),
      .data     (sel_data),
      .busy     (busy),
      .done     (ser_done),
      .txd      (uart_txd)
   );

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb (CLKS_PER_BIT=4,
// LOCK_TIMEOUT=8). A line monitor decodes every frame and compares it with
// the byte queue filled by the stimulus side.
module tb_uart_tx_arb;

   localparam int CPB  = 4;
   localparam int LT   = 8;
   localparam int HALF = CPB / 2;

   logic       clk_50MHz = 1'b0;
   logic       arst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_last = 1'b0, req1_last = 1'b0;
   logic       req0_ready, req1_ready;
   logic [1:0] grant;
   logic       busy;
   logic       uart_txd;

   uart_tx_arb #(.CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LT)) dut (
      .clk_50MHz (clk_50MHz),
      .arst_n    (arst_n),
      .req0_valid(req0_valid),
      .req0_data (req0_data),
      .req0_last (req0_last),
      .req1_valid(req1_valid),
      .req1_data (req1_data),
      .req1_last (req1_last),
      .req0_ready(req0_ready),
      .req1_ready(req1_ready),
      .grant     (grant),
      .busy      (busy),
      .uart_txd  (uart_txd)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int cyc = 0;
   always @(posedge clk_50MHz) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];
   int         mon_starts[$];

   typedef struct {
      int         r;
      logic [7:0] d;
      logic [1:0] g;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
      if (r == 0) begin
         req0_valid = v; req0_data = d; req0_last = l;
      end else begin
         req1_valid = v; req1_data = d; req1_last = l;
      end
   endtask

   function automatic logic ready_of(input int r);
      return (r == 0) ? req0_ready : req1_ready;
   endfunction

   // expected line level in bit period g of a frame carrying d
   function automatic logic frame_bit(input logic [7:0] d, input int g);
      if (g == 0) return 1'b0;
      if (g >= 9) return 1'b1;
      return d[g-1];
   endfunction

   task automatic send(input int r, input logic [7:0] d, input logic l,
                       output int acc, output bit ok);
      ok  = 1'b0;
      acc = -1;
      @(negedge clk_50MHz);
      set_req(r, 1'b1, d, l);
      for (int i = 0; i < 400; i++) begin
         #1;
         if (ready_of(r)) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
         @(negedge clk_50MHz);
      end
      check($sformatf("accept_req%0d", r), {31'b0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk_50MHz);
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      arst_n = 1'b0;
      @(negedge clk_50MHz);
      @(negedge clk_50MHz);
      #1;
      check("rst_txd", {31'b0, uart_txd}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_grant", {30'b0, grant}, 32'd0);
      check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      arst_n = 1'b1;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_50MHz);
         #1;
         if (!busy && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check("drain", {31'b0, done}, 32'd1);
   endtask

   // line monitor: decode frames mid-bit, abandon any frame cut by reset
   initial begin
      logic [7:0]  data;
      logic [31:0] exp;
      bit          aborted;
      int          bi;
      forever begin
         @(negedge clk_50MHz);
         #2;
         if (arst_n && uart_txd === 1'b0) begin
            mon_starts.push_back(cyc);
            aborted = 1'b0;
            data    = 8'h00;
            for (int k = 1; k <= 9 * CPB + HALF; k++) begin
               @(negedge clk_50MHz);
               #2;
               if (!arst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (k == HALF) begin
                  check("uart_start_bit", {31'b0, uart_txd}, 32'd0);
               end else if (k >= CPB + HALF && (k - HALF) % CPB == 0) begin
                  bi = (k - HALF) / CPB - 1;
                  if (bi < 8) data[bi] = uart_txd;
                  else check("uart_stop_bit", {31'b0, uart_txd}, 32'd1);
               end
            end
            if (aborted) begin
               while (!arst_n) begin
                  @(negedge clk_50MHz);
                  #2;
               end
            end else begin
               exp = 'x;
               if (sb.size() > 0) exp = {24'h0, sb.pop_front()};
               check("uart_byte", {24'h0, data}, exp);
            end
         end
      end
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   acc, n, n0, bad, busy_bad, r1_early, bad_grant;
      bit   ok, r1_seen;
      int   exp_r[3];

      vecs[0] = '{0, 8'hA5, 2'b01};
      vecs[1] = '{1, 8'h00, 2'b10};
      vecs[2] = '{1, 8'h81, 2'b10};
      vecs[3] = '{0, 8'hFF, 2'b01};

      // single-byte packets: waveform, busy length, grant set and released
      do_reset();
      for (int v = 0; v < 4; v++) begin
         sb.push_back(vecs[v].d);
         send(vecs[v].r, vecs[v].d, 1'b1, acc, ok);
         bad      = 0;
         busy_bad = 0;
         for (int j = 1; j <= 10 * CPB + 1; j++) begin
            @(negedge clk_50MHz);
            #1;
            if (j == 1) begin
               check("ready_one_cycle", {31'b0, ready_of(vecs[v].r)}, 32'd0);
               check("grant_owner", {30'b0, grant}, {30'b0, vecs[v].g});
               set_req(vecs[v].r, 1'b0, vecs[v].d, 1'b0);
            end
            if (j <= 10 * CPB) begin
               if (uart_txd !== frame_bit(vecs[v].d, (j - 1) / CPB)) bad++;
               if (busy !== 1'b1) busy_bad++;
            end else begin
               check("busy_after_frame", {31'b0, busy}, 32'd0);
               check("grant_released", {30'b0, grant}, 32'd0);
            end
         end
         check($sformatf("txd_wave_%02h", vecs[v].d), bad, 0);
         check("busy_40_cycles", busy_bad, 0);
      end
      wait_idle();

      // contention from reset: 0x11, 0x22, 0x11, frames 41 cycles apart
      do_reset();
      mon_starts.delete();
      sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h11);
      exp_r = '{0, 1, 0};
      set_req(0, 1'b1, 8'h11, 1'b1);
      set_req(1, 1'b1, 8'h22, 1'b1);
      n = 0;
      for (int c = 0; c < 400; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            check("contention_winner", {30'b0, req1_ready, req0_ready},
                  (exp_r[n] == 1) ? 32'd2 : 32'd1);
            n++;
            if (n == 3) break;
         end
         @(negedge clk_50MHz);
      end
      @(negedge clk_50MHz);
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      check("contention_accepts", n, 3);
      wait_idle();
      check("contention_frames", mon_starts.size(), 3);
      if (mon_starts.size() == 3) begin
         check("frame_spacing_1", mon_starts[1] - mon_starts[0], 10 * CPB + 1);
         check("frame_spacing_2", mon_starts[2] - mon_starts[1], 10 * CPB + 1);
      end

      // lock: 3-byte req0 packet while req1 is held valid
      do_reset();
      sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03); sb.push_back(8'h5A);
      set_req(0, 1'b1, 8'h01, 1'b0);
      set_req(1, 1'b1, 8'h5A, 1'b1);
      n0 = 0; r1_seen = 1'b0; r1_early = 0; bad_grant = 0;
      for (int c = 0; c < 600; c++) begin
         if (c > 0) begin
            @(negedge clk_50MHz);
            if (n0 == 1) set_req(0, 1'b1, 8'h02, 1'b0);
            else if (n0 == 2) set_req(0, 1'b1, 8'h03, 1'b1);
            else if (n0 == 3) set_req(0, 1'b0, 8'h03, 1'b1);
         end
         #1;
         if (req1_ready) begin
            r1_seen = 1'b1;
            if (n0 < 3) r1_early++;
            break;
         end
         if (n0 > 0 && grant !== 2'b01) bad_grant++;
         if (req0_ready) n0++;
      end
      @(negedge clk_50MHz);
      set_req(1, 1'b0, 8'h00, 1'b0);
      check("lock_req0_bytes", n0, 3);
      check("lock_req1_served", {31'b0, r1_seen}, 32'd1);
      check("lock_no_early_req1", r1_early, 0);
      check("lock_grant_held", bad_grant, 0);
      wait_idle();

      // timeout: req0 leaves its packet open, req1 waits
      do_reset();
      sb.push_back(8'h3C); sb.push_back(8'hC3);
      send(0, 8'h3C, 1'b0, acc, ok);
      @(negedge clk_50MHz);
      #1;
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b1, 8'hC3, 1'b1);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         @(negedge clk_50MHz);
         #1;
      end
      bad = 0;
      for (int k = 1; k <= LT; k++) begin
         if (k > 1) begin
            @(negedge clk_50MHz);
            #1;
         end
         if (grant !== 2'b01 || req1_ready !== 1'b0) bad++;
      end
      check("lock_hold_before_timeout", bad, 0);
      @(negedge clk_50MHz);
      #1;
      check("grant_cleared_on_timeout", {30'b0, grant}, 32'd0);
      check("req1_accept_after_timeout", {31'b0, req1_ready}, 32'd1);
      @(negedge clk_50MHz);
      set_req(1, 1'b0, 8'h00, 1'b0);
      wait_idle();

      // reset during DATA bit 3: abort, line high, aborted byte not resent
      do_reset();
      send(0, 8'h96, 1'b0, acc, ok);
      for (int j = 1; j <= 4 * CPB + 2; j++) begin
         @(negedge clk_50MHz);
         if (j == 1) set_req(0, 1'b0, 8'h00, 1'b0);
      end
      #1;
      check("pre_reset_bit3", {31'b0, uart_txd}, 32'd0);
      arst_n = 1'b0;
      @(negedge clk_50MHz);
      #1;
      check("abort_txd", {31'b0, uart_txd}, 32'd1);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_grant", {30'b0, grant}, 32'd0);
      arst_n = 1'b1;
      sb.push_back(8'h77);
      send(1, 8'h77, 1'b1, acc, ok);
      @(negedge clk_50MHz);
      #1;
      check("post_reset_grant_req1", {30'b0, grant}, 32'd2);
      set_req(1, 1'b0, 8'h00, 1'b0);
      wait_idle();

      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
